// File: rtl/executor.sv
// Execute stage of the RV32IM pipeline: ALU, address, branch and multiply in one cycle,
// plus a restoring divider FSM that stalls register-read while it iterates.
module executor #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_noop,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        stall,
  output logic        out_noop,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic [31:0] out_res,
  output logic [31:0] out_rs2_data,
  output logic        out_branch_taken,
  output logic [31:0] out_branch_target
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;

  localparam int CW = $clog2(DIV_ITERS);
  // RUN covers DIV_ITERS-1 steps; the final step is folded into FINISH.
  localparam logic [CW-1:0] COUNT_INIT = CW'(DIV_ITERS - 2);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;

  logic [31:0] a, b, op_b, alu_res, sum_ai;
  logic [31:0] norm_res, norm_target, mul_res, quick_div_res;
  logic        norm_taken, br_cond;
  logic        is_m, is_div, div_signed, div_zero, div_ovf, div_long, accept;
  logic [63:0] product;
  logic        mul_a_signed, mul_b_signed;
  logic [31:0] a_abs, b_abs;

  logic [31:0]   quo_q, rem_q, dvs_q;
  logic [CW-1:0] count;
  logic          q_neg, r_neg, want_rem;
  logic [32:0]   shifted, diff;
  logic [31:0]   step_quo, step_rem, div_result;

  logic        stall_raw, noop_next, taken_next;
  logic [31:0] res_next, target_next;

  assign a      = in_rs1_data;
  assign b      = in_rs2_data;
  assign sum_ai = a + in_imm;

  assign is_m       = (in_opcode == OP_R) && (in_funct7 == 7'b0000001);
  assign is_div     = is_m && in_funct3[2];
  assign div_signed = ~in_funct3[0];
  assign div_zero   = (b == 32'd0);
  assign div_ovf    = div_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div_long   = is_div && !div_zero && !div_ovf;
  assign accept     = (state == IDLE) && !in_noop && div_long;

  assign a_abs = (div_signed && a[31]) ? (32'd0 - a) : a;
  assign b_abs = (div_signed && b[31]) ? (32'd0 - b) : b;

  // One multiplier: the low word is the same for every signedness, so only MULH* differ.
  assign mul_a_signed = (in_funct3[1:0] != 2'b11);
  assign mul_b_signed = ~in_funct3[1];
  assign product = {{32{mul_a_signed & a[31]}}, a} * {{32{mul_b_signed & b[31]}}, b};
  assign mul_res = (in_funct3[1:0] == 2'b00) ? product[31:0] : product[63:32];

  assign quick_div_res = div_zero ? (in_funct3[1] ? a : 32'hFFFF_FFFF)
                                  : (in_funct3[1] ? 32'd0 : 32'h8000_0000);

  always_comb begin
    op_b = (in_opcode == OP_R) ? b : in_imm;
    case (in_funct3)
      3'b000:  alu_res = ((in_opcode == OP_R) && in_funct7[5]) ? a - op_b : a + op_b;
      3'b001:  alu_res = a << op_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(a) < $signed(op_b)};
      3'b011:  alu_res = {31'd0, a < op_b};
      3'b100:  alu_res = a ^ op_b;
      3'b101:  alu_res = in_funct7[5] ? 32'($signed(a) >>> op_b[4:0]) : a >> op_b[4:0];
      3'b110:  alu_res = a | op_b;
      default: alu_res = a & op_b;
    endcase
  end

  always_comb begin
    case (in_funct3)
      3'b000:  br_cond = (a == b);
      3'b001:  br_cond = (a != b);
      3'b100:  br_cond = $signed(a) < $signed(b);
      3'b101:  br_cond = $signed(a) >= $signed(b);
      3'b110:  br_cond = a < b;
      3'b111:  br_cond = a >= b;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    norm_res    = 32'd0;
    norm_taken  = 1'b0;
    norm_target = in_pc + in_imm;
    case (in_opcode)
      OP_R:     norm_res = is_m ? (in_funct3[2] ? quick_div_res : mul_res) : alu_res;
      OP_I:     norm_res = alu_res;
      OP_LUI:   norm_res = in_imm;
      OP_AUIPC: norm_res = in_pc + in_imm;
      OP_JAL: begin
        norm_res   = in_pc + 32'd4;
        norm_taken = 1'b1;
      end
      OP_JALR: begin
        norm_res    = in_pc + 32'd4;
        norm_taken  = 1'b1;
        norm_target = sum_ai & ~32'd1;
      end
      OP_BR:        norm_taken = br_cond;
      OP_LD, OP_ST: norm_res = sum_ai;
      default: ;
    endcase
  end

  // Restoring step: remainder stays below the divisor, so 33 bits suffice for the trial subtract.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
  assign step_quo = {quo_q[30:0], ~diff[32]};
  assign div_result = want_rem ? (r_neg ? 32'd0 - step_rem : step_rem)
                               : (q_neg ? 32'd0 - step_quo : step_quo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (count == '0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_raw   = 1'b0;
    noop_next   = in_noop;
    res_next    = norm_res;
    taken_next  = norm_taken & ~in_noop;
    target_next = norm_target;
    case (state)
      IDLE: if (accept) begin
        stall_raw  = 1'b1;
        noop_next  = 1'b1;
        taken_next = 1'b0;
      end
      RUN: begin
        stall_raw  = 1'b1;
        noop_next  = 1'b1;
        taken_next = 1'b0;
      end
      FINISH: begin
        noop_next  = 1'b0;
        taken_next = 1'b0;
        res_next   = div_result;
      end
      default: ;
    endcase
  end

  assign stall = stall_raw & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      count    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      want_rem <= 1'b0;
    end else if (accept) begin
      quo_q    <= a_abs;
      rem_q    <= '0;
      dvs_q    <= b_abs;
      count    <= COUNT_INIT;
      q_neg    <= div_signed & (a[31] ^ b[31]);
      r_neg    <= div_signed & a[31];
      want_rem <= in_funct3[1];
    end else if (state == RUN) begin
      quo_q <= step_quo;
      rem_q <= step_rem;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_noop          <= 1'b1;
      out_opcode        <= '0;
      out_rd            <= '0;
      out_imm           <= '0;
      out_res           <= '0;
      out_rs2_data      <= '0;
      out_branch_taken  <= 1'b0;
      out_branch_target <= '0;
    end else begin
      out_noop          <= noop_next;
      out_opcode        <= in_opcode;
      out_rd            <= in_rd;
      out_imm           <= in_imm;
      out_res           <= res_next;
      out_rs2_data      <= in_rs2_data;
      out_branch_taken  <= taken_next;
      out_branch_target <= target_next;
    end
  end

endmodule

// File: tb/tb_executor.sv
// Bench for executor: directed test-plan cases with literal results, then random
// instructions checked every cycle against an instruction-level reference model.
module tb_executor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [31:0] in_imm, in_pc, in_rs1_data, in_rs2_data;
  logic        stall, out_noop, out_branch_taken;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [31:0] out_imm, out_res, out_rs2_data, out_branch_target;

  executor dut (
    .clk(clk), .rst(rst), .in_noop(in_noop), .in_opcode(in_opcode),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_imm(in_imm),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .stall(stall), .out_noop(out_noop), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_imm(out_imm), .out_res(out_res), .out_rs2_data(out_rs2_data),
    .out_branch_taken(out_branch_taken), .out_branch_target(out_branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        noop;
    logic [31:0] res;
    logic        taken;
    logic [31:0] target;
    bit          long_div;
  } model_t;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_noop = 1'b1, exp_taken = 1'b0;
  logic [31:0] exp_res = '0, exp_target = '0;
  logic [6:0]  exp_opcode = '0;
  logic [4:0]  exp_rd = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] f3, input bit alt, input bit is_r);
    int sx, sy;
    sx = x;
    sy = y;
    case (f3)
      3'd0:    return (is_r && alt) ? x - y : x + y;
      3'd1:    return x << y[4:0];
      3'd2:    return (sx < sy) ? 32'd1 : 32'd0;
      3'd3:    return (x < y) ? 32'd1 : 32'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? 32'(sx >>> y[4:0]) : x >> y[4:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic model_t ref_exec(input logic noop, input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] pc,
                                      input logic [31:0] imm, input logic [31:0] x,
                                      input logic [31:0] y);
    model_t m;
    int sx, sy;
    longint p;
    logic [63:0] pu;
    logic [31:0] q, r, t;
    bit cond;
    sx = x;
    sy = y;
    m.noop = noop; m.res = '0; m.taken = 1'b0; m.target = pc + imm; m.long_div = 1'b0;
    cond = 1'b0;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000001) begin
          case (f3)
            3'd0: begin p = longint'(sx) * longint'(sy); m.res = p[31:0]; end
            3'd1: begin p = longint'(sx) * longint'(sy); m.res = p[63:32]; end
            3'd2: begin p = longint'(sx) * longint'({32'd0, y}); m.res = p[63:32]; end
            3'd3: begin pu = {32'd0, x} * {32'd0, y}; m.res = pu[63:32]; end
            default: begin
              if (y == 32'd0) begin
                q = 32'hFFFF_FFFF; r = x;
              end else if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
              end else begin
                m.long_div = !noop;
                if (!f3[0]) begin q = sx / sy; r = sx % sy; end
                else        begin q = x / y;   r = x % y;   end
              end
              m.res = f3[1] ? r : q;
            end
          endcase
        end else m.res = ref_alu(x, y, f3, f7[5], 1'b1);
      end
      7'b0010011: m.res = ref_alu(x, imm, f3, f7[5], 1'b0);
      7'b0110111: m.res = imm;
      7'b0010111: m.res = pc + imm;
      7'b1101111: begin m.res = pc + 4; m.taken = 1'b1; end
      7'b1100111: begin
        m.res = pc + 4; m.taken = 1'b1;
        t = x + imm; t[0] = 1'b0; m.target = t;
      end
      7'b1100011: begin
        case (f3)
          3'd0: cond = (x == y);
          3'd1: cond = (x != y);
          3'd4: cond = (sx < sy);
          3'd5: cond = (sx >= sy);
          3'd6: cond = (x < y);
          3'd7: cond = (x >= y);
          default: cond = 1'b0;
        endcase
        m.taken = cond;
      end
      7'b0000011, 7'b0100011: m.res = x + imm;
      default: ;
    endcase
    if (noop) m.taken = 1'b0;
    return m;
  endfunction

  // Drive one instruction at a negedge, hold it through any divide, return at the negedge after its result edge.
  task automatic apply_stimulus(input logic noop, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] x, input logic [31:0] y);
    model_t m;
    in_noop = noop; in_opcode = op; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    in_pc = pc; in_imm = imm; in_rs1_data = x; in_rs2_data = y;
    m = ref_exec(noop, op, f3, f7, pc, imm, x, y);
    exp_opcode = op; exp_rd = rd; exp_res = m.res; exp_target = m.target;
    if (m.long_div) begin
      for (int c = 1; c <= 33; c++) begin
        exp_stall = (c <= 32);
        exp_noop  = (c <= 32);
        exp_taken = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
    end else begin
      exp_stall = 1'b0;
      exp_noop  = m.noop;
      exp_taken = m.taken;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) check_output("stall", 32'(stall), 32'(exp_stall));
      @(posedge clk);
      #1;
      if (chk_en) begin
        check_output("out_noop", 32'(out_noop), 32'(exp_noop));
        check_output("out_branch_taken", 32'(out_branch_taken), 32'(exp_taken));
        check_output("out_opcode", 32'(out_opcode), 32'(exp_opcode));
        check_output("out_rd", 32'(out_rd), 32'(exp_rd));
        if (!exp_noop) check_output("out_res", out_res, exp_res);
        if (exp_taken) check_output("out_branch_target", out_branch_target, exp_target);
      end
    end
  end

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  localparam logic [6:0] R = 7'b0110011;

  initial begin
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] x, y;
    logic [6:0]  unknown_ops [4];
    unknown_ops[0] = 7'b1111111; unknown_ops[1] = 7'b0001111;
    unknown_ops[2] = 7'b1110011; unknown_ops[3] = 7'b0000000;

    rst = 1'b1;
    in_noop = 1'b1; in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0;
    in_imm = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    repeat (2) @(negedge clk);
    check_output("reset_out_noop", 32'(out_noop), 32'd1);
    check_output("reset_taken", 32'(out_branch_taken), 32'd0);
    check_output("reset_res", out_res, 32'd0);
    check_output("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    apply_stimulus(1'b0, R, 3'd0, 7'd0, 5'd1, 32'h0, 32'h0, 32'd10, 32'd20);
    // Asynchronous reset between edges, with a divide waiting on the inputs.
    chk_en = 1'b0;
    in_noop = 1'b0; in_opcode = R; in_funct3 = 3'd4; in_funct7 = 7'd1;
    in_rs1_data = 32'd100; in_rs2_data = 32'd7;
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_noop", 32'(out_noop), 32'd1);
    check_output("async_reset_stall", 32'(stall), 32'd0);
    in_noop = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    apply_stimulus(1'b0, R, 3'd0, 7'd0, 5'd2, 32'h0, 32'h0, 32'd5, 32'hFFFF_FFF9);
    check_output("add_5_m7", out_res, 32'hFFFF_FFFE);
    apply_stimulus(1'b0, R, 3'd5, 7'h20, 5'd3, 32'h0, 32'h0, 32'h8000_0000, 32'd4);
    check_output("sra", out_res, 32'hF800_0000);
    apply_stimulus(1'b0, R, 3'd3, 7'd0, 5'd4, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFF);
    check_output("sltu", out_res, 32'd1);
    apply_stimulus(1'b0, 7'b0010111, 3'd0, 7'd0, 5'd5, 32'h100, 32'h2000, 32'd0, 32'd0);
    check_output("auipc", out_res, 32'h2100);
    apply_stimulus(1'b0, 7'b1100011, 3'd4, 7'd0, 5'd0, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0);
    check_output("blt_taken", 32'(out_branch_taken), 32'd1);
    check_output("blt_target", out_branch_target, 32'h38);
    apply_stimulus(1'b1, 7'b1100011, 3'd4, 7'd0, 5'd0, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0);
    check_output("blt_noop_taken", 32'(out_branch_taken), 32'd0);
    apply_stimulus(1'b0, 7'b1100111, 3'd0, 7'd0, 5'd1, 32'h200, 32'd2, 32'h1001, 32'd0);
    check_output("jalr_target", out_branch_target, 32'h1002);
    check_output("jalr_res", out_res, 32'h204);
    apply_stimulus(1'b0, R, 3'd4, 7'd1, 5'd6, 32'h0, 32'h0, 32'hFFFF_FF9C, 32'd7);
    check_output("div_m100_7", out_res, 32'hFFFF_FFF2);
    apply_stimulus(1'b0, R, 3'd6, 7'd1, 5'd7, 32'h0, 32'h0, 32'hFFFF_FF9C, 32'd7);
    check_output("rem_m100_7", out_res, 32'hFFFF_FFFE);
    apply_stimulus(1'b0, R, 3'd5, 7'd1, 5'd8, 32'h0, 32'h0, 32'd100, 32'd7);
    check_output("divu_100_7", out_res, 32'd14);
    apply_stimulus(1'b0, R, 3'd4, 7'd1, 5'd9, 32'h0, 32'h0, 32'd55, 32'd0);
    check_output("div_by_zero", out_res, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, R, 3'd4, 7'd1, 5'd10, 32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("div_overflow", out_res, 32'h8000_0000);
    apply_stimulus(1'b0, R, 3'd1, 7'd1, 5'd11, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'd3);
    check_output("mulh", out_res, 32'hFFFF_FFFF);
    apply_stimulus(1'b0, R, 3'd3, 7'd1, 5'd12, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd2);
    check_output("mulhu", out_res, 32'd1);

    // Reset pulsed while the divider is in RUN.
    in_noop = 1'b0; in_opcode = R; in_funct3 = 3'd4; in_funct7 = 7'd1; in_rd = 5'd13;
    in_rs1_data = 32'd1000; in_rs2_data = 32'd3;
    exp_opcode = R; exp_rd = 5'd13;
    for (int c = 1; c <= 10; c++) begin
      exp_stall = 1'b1;
      exp_noop  = 1'b1;
      exp_taken = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_output("run_reset_stall", 32'(stall), 32'd0);
    check_output("run_reset_noop", 32'(out_noop), 32'd1);
    in_noop = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("post_reset_stall", 32'(stall), 32'd0);
    chk_en = 1'b1;
    apply_stimulus(1'b0, R, 3'd0, 7'd0, 5'd14, 32'h0, 32'h0, 32'd40, 32'd2);
    check_output("add_after_reset", out_res, 32'd42);

    for (int i = 0; i < 400; i++) begin
      x = rand_val();
      y = rand_val();
      f7 = 7'd0;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 15))
        0, 1, 2, 3: begin
          op = R;
          if (f3 == 3'd0 || f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end
        4, 5, 6: begin
          op = 7'b0010011;
          if (f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
          else if (f3 != 3'd1) f7 = 7'($urandom);
        end
        7:  op = 7'b0110111;
        8:  op = 7'b0010111;
        9:  op = 7'b1101111;
        10: op = 7'b1100111;
        11: begin
          op = 7'b1100011;
          f3 = 3'($urandom_range(2, 7));
          if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 - 3'd2;
        end
        12: op = $urandom_range(0, 1) ? 7'b0000011 : 7'b0100011;
        13: begin op = R; f7 = 7'd1; f3 = 3'($urandom_range(0, 3)); end
        14: begin
          op = R; f7 = 7'd1; f3 = 3'($urandom_range(4, 7));
          case ($urandom_range(0, 5))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            default: ;
          endcase
        end
        default: op = unknown_ops[$urandom_range(0, 3)];
      endcase
      apply_stimulus($urandom_range(0, 7) == 0, op, f3, f7, 5'($urandom), $urandom, rand_val(), x, y);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
